// File: rtl/fifo_pkg.sv
// fifo_pkg: shared types and sizing helpers for the FIFO read-side blocks.
package fifo_pkg;
    typedef enum logic [1:0] {IDLE, BURST, DRAIN} burst_state_t;

    function automatic int lw_of(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction
endpackage

// File: rtl/fifo_burst_reader_skid.sv
// skid_buffer: 2-entry registered valid/ready stage; in_ready comes from a flop so
// no combinational path exists from out_ready back to the producer.
module skid_buffer #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);
    logic             buf_valid;
    logic [WIDTH-1:0] buf_data;
    logic             push;

    assign in_ready = !buf_valid;
    assign push     = in_valid && in_ready;

    // The second entry only fills when the head is stalled, so occupancy < 2 == !buf_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            buf_valid <= 1'b0;
            buf_data  <= '0;
        end else if (!out_valid || out_ready) begin
            if (buf_valid) begin
                out_valid <= 1'b1;
                out_data  <= buf_data;
                buf_valid <= 1'b0;
            end else begin
                out_valid <= push;
                if (push) out_data <= in_data;
            end
        end else if (push) begin
            buf_valid <= 1'b1;
            buf_data  <= in_data;
        end
    end
endmodule

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: pops host-requested bursts from a show-ahead FIFO and streams
// them out through a skid stage with an end-of-burst marker.
module fifo_burst_reader
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 16,
    localparam int LW       = lw_of(MAX_BURST)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LW-1:0]    cmd_len,
    input  logic [WIDTH-1:0] fifo_data,
    input  logic             fifo_valid,
    output logic             fifo_ren,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             busy
);
    burst_state_t  state;
    logic [LW-1:0] remaining;
    logic          skid_in_ready;

    assign fifo_ren  = (state == BURST) && fifo_valid && skid_in_ready;
    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            remaining <= '0;
        end else begin
            case (state)
                IDLE:
                    if (cmd_valid && cmd_len != '0) begin
                        remaining <= cmd_len;
                        state     <= BURST;
                    end
                BURST:
                    if (fifo_ren) begin
                        remaining <= remaining - 1'b1;
                        if (remaining == LW'(1)) state <= DRAIN;
                    end
                // The last beat is the final word pushed, so its handshake empties the skid.
                DRAIN:
                    if (!out_valid || (out_ready && out_last)) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    skid_buffer #(.WIDTH(WIDTH + 1)) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (fifo_ren),
        .in_ready (skid_in_ready),
        .in_data  ({fifo_data, remaining == LW'(1)}),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data ({out_data, out_last})
    );
endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader: directed scenarios against a show-ahead FIFO model and a
// beat monitor; each task checks its own expectations inline.
module tb_fifo_burst_reader;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [4:0] cmd_len = '0;
    logic [7:0] fifo_data;
    logic       fifo_valid;
    logic       fifo_ren;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic       out_last;
    logic       busy;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int rd = 0;
    int wr = 0;
    int ren_cnt = 0;
    int vcnt = 0;
    logic [7:0] mem [0:255];
    logic [7:0] got_d[$];
    logic       got_l[$];
    int         got_c[$];

    fifo_burst_reader dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_len(cmd_len), .fifo_data(fifo_data), .fifo_valid(fifo_valid),
        .fifo_ren(fifo_ren), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign fifo_valid = (rd != wr);
    assign fifo_data  = mem[rd[7:0]];

    always @(posedge clk) begin
        if (fifo_ren) begin
            rd      <= rd + 1;
            ren_cnt <= ren_cnt + 1;
        end
    end

    always @(negedge clk) begin
        if (out_valid) vcnt <= vcnt + 1;
        if (out_valid && out_ready) begin
            got_d.push_back(out_data);
            got_l.push_back(out_last);
            got_c.push_back(cyc);
        end
    end

    task automatic push(input logic [7:0] v);
        mem[wr[7:0]] = v;
        wr++;
    endtask

    task automatic clear_mon();
        got_d.delete();
        got_l.delete();
        got_c.delete();
    endtask

    task automatic send_cmd(input logic [4:0] len, output int base);
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_len   = len;
        base      = cyc;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_beats(input int n, input string name);
        int k = 0;
        while (got_d.size() < n && k < 200) begin
            @(negedge clk);
            #1;
            k++;
        end
        tests++;
        if (got_d.size() < n) begin
            fails++;
            $display("FAIL %s timeout: got %0d beats, required %0d", name, got_d.size(), n);
        end
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if ({out_valid, out_data, out_last, fifo_ren, busy, cmd_ready} !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL reset_values got v=%b d=%h l=%b ren=%b busy=%b rdy=%b", out_valid, out_data, out_last, fifo_ren, busy, cmd_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL post_reset_idle got rdy=%b busy=%b required 1/0", cmd_ready, busy);
        end
    endtask

    task automatic test_basic();
        int base;
        for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i));
        clear_mon();
        send_cmd(5'd4, base);
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL basic_busy got %b required 1", busy);
        end
        wait_cyc(base + 5);
        tests++;
        if (cmd_ready !== 1'b0) begin
            fails++;
            $display("FAIL basic_cmd_ready_early got %b required 0", cmd_ready);
        end
        wait_cyc(base + 6);
        tests++;
        if (cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL basic_cmd_ready got %b required 1", cmd_ready);
        end
        wait_beats(4, "basic");
        for (int i = 0; i < 4 && i < got_d.size(); i++) begin
            logic [7:0] e;
            e = 8'hA0 + 8'(i);
            tests++;
            if (got_d[i] !== e || got_l[i] !== (i == 3) || got_c[i] != base + 2 + i) begin
                fails++;
                $display("FAIL basic_beat%0d got d=%h l=%b cyc=%0d required d=%h l=%b cyc=%0d", i, got_d[i], got_l[i], got_c[i], e, i == 3, base + 2 + i);
            end
        end
    endtask

    task automatic test_empty_stall();
        int base;
        int r0;
        int v0;
        push(8'h11);
        clear_mon();
        r0 = ren_cnt;
        v0 = vcnt;
        send_cmd(5'd3, base);
        repeat (5) @(posedge clk);
        #1;
        tests++;
        if (got_d.size() != 1 || ren_cnt - r0 != 1) begin
            fails++;
            $display("FAIL stall_gap got beats=%0d pops=%0d required 1/1", got_d.size(), ren_cnt - r0);
        end
        push(8'h22);
        push(8'h33);
        wait_beats(3, "stall");
        @(negedge clk);
        #1;
        tests++;
        if (got_d.size() != 3 || got_d[0] !== 8'h11 || got_d[1] !== 8'h22 || got_d[2] !== 8'h33 ||
            got_l[0] !== 1'b0 || got_l[1] !== 1'b0 || got_l[2] !== 1'b1) begin
            fails++;
            $display("FAIL stall_data got n=%0d required 11,22,33 with last on 33", got_d.size());
        end
        tests++;
        if (vcnt - v0 != 3) begin
            fails++;
            $display("FAIL stall_valid_cycles got %0d required 3", vcnt - v0);
        end
    endtask

    task automatic test_backpressure();
        int base;
        int rd0;
        int stall_pops = 0;
        int stable_bad = 0;
        logic prev_stall = 1'b0;
        logic [7:0] prev_d = '0;
        for (int i = 0; i < 8; i++) push(8'h50 + 8'(i));
        clear_mon();
        rd0 = rd;
        send_cmd(5'd6, base);
        for (int i = 0; i < 25; i++) begin
            out_ready = !(cyc >= base + 4 && cyc <= base + 6);
            @(negedge clk);
            if (!out_ready && fifo_ren) stall_pops++;
            if (prev_stall && out_data !== prev_d) stable_bad++;
            prev_stall = out_valid && !out_ready;
            prev_d     = out_data;
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        wait_beats(6, "backpressure");
        tests++;
        if (stable_bad != 0) begin
            fails++;
            $display("FAIL bp_stable got %0d changes while stalled required 0", stable_bad);
        end
        tests++;
        if (stall_pops > 2) begin
            fails++;
            $display("FAIL bp_extra_pops got %0d required <=2", stall_pops);
        end
        tests++;
        if (rd - rd0 != 6 || got_d.size() != 6) begin
            fails++;
            $display("FAIL bp_count got pops=%0d beats=%0d required 6/6", rd - rd0, got_d.size());
        end
        for (int i = 0; i < 6 && i < got_d.size(); i++) begin
            logic [7:0] e;
            e = 8'h50 + 8'(i);
            tests++;
            if (got_d[i] !== e || got_l[i] !== (i == 5)) begin
                fails++;
                $display("FAIL bp_beat%0d got d=%h l=%b required d=%h l=%b", i, got_d[i], got_l[i], e, i == 5);
            end
        end
    endtask

    task automatic test_zero_len();
        int base;
        int r0;
        int v0;
        int busy_seen = 0;
        clear_mon();
        r0 = ren_cnt;
        v0 = vcnt;
        send_cmd(5'd0, base);
        @(negedge clk);
        tests++;
        if (cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL zero_cmd_ready got %b required 1", cmd_ready);
        end
        for (int i = 0; i < 4; i++) begin
            if (busy !== 1'b0) busy_seen++;
            @(negedge clk);
        end
        tests++;
        if (busy_seen != 0 || ren_cnt != r0 || vcnt != v0) begin
            fails++;
            $display("FAIL zero_len got busy=%0d pops=%0d valids=%0d required 0/0/0", busy_seen, ren_cnt - r0, vcnt - v0);
        end
    endtask

    task automatic test_max_burst();
        int base;
        int cnt0;
        int rd0;
        for (int i = 0; i < 16; i++) push(8'hC0 + 8'(i));
        clear_mon();
        cnt0 = wr - rd;
        rd0  = rd;
        send_cmd(5'd16, base);
        wait_beats(16, "max_burst");
        repeat (3) @(negedge clk);
        tests++;
        if (wr - rd != cnt0 - 16 || got_d.size() != 16) begin
            fails++;
            $display("FAIL max_count got fifo=%0d beats=%0d required %0d/16", wr - rd, got_d.size(), cnt0 - 16);
        end
        for (int i = 0; i < 16 && i < got_d.size(); i++) begin
            logic [7:0] e;
            e = mem[8'(rd0 + i)];
            tests++;
            if (got_d[i] !== e || got_l[i] !== (i == 15)) begin
                fails++;
                $display("FAIL max_beat%0d got d=%h l=%b required d=%h l=%b", i, got_d[i], got_l[i], e, i == 15);
            end
        end
    endtask

    task automatic test_mid_reset();
        int base;
        int r;
        for (int i = 0; i < 8; i++) push(8'hE0 + 8'(i));
        clear_mon();
        send_cmd(5'd8, base);
        wait_beats(2, "mid_reset_pre");
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({out_valid, out_data, out_last, fifo_ren, busy, cmd_ready} !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL mid_reset_values got v=%b d=%h l=%b ren=%b busy=%b rdy=%b", out_valid, out_data, out_last, fifo_ren, busy, cmd_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        r = rd;
        clear_mon();
        send_cmd(5'd2, base);
        wait_beats(2, "mid_reset_post");
        wait_cyc(base + 4);
        tests++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || rd - r != 2) begin
            fails++;
            $display("FAIL post_reset_done got rdy=%b busy=%b pops=%0d required 1/0/2", cmd_ready, busy, rd - r);
        end
        for (int i = 0; i < 2 && i < got_d.size(); i++) begin
            logic [7:0] e;
            e = mem[8'(r + i)];
            tests++;
            if (got_d[i] !== e || got_l[i] !== (i == 1)) begin
                fails++;
                $display("FAIL post_reset_beat%0d got d=%h l=%b required d=%h l=%b", i, got_d[i], got_l[i], e, i == 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_empty_stall();
        test_backpressure();
        test_zero_len();
        test_max_burst();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
